// File: rtl/uart_rx_irq.sv
// uart_rx_irq -- 8N1 UART receive front end with a level interrupt request.
//
// Deserialises frames from the asynchronous rx pin, presents each good byte
// on r_data and raises irr until the CPU acknowledges with a rising edge on
// ack. Stop-bit errors and bytes arriving while irr is pending are reported
// on sticky flags that the same ack edge clears.
//
// Ports:
//   clk        in   1  clock, all state on rising edge
//   reset      in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial line, idles high
//   ack        in   1  CPU acknowledge level; only its rising edge acts
//   irr        out  1  a received byte is pending
//   r_data     out  8  last valid received byte
//   frame_err  out  1  sticky: stop bit sampled low
//   overrun    out  1  sticky: byte completed while irr already pending
module uart_rx_irq #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       ack,
    output logic       irr,
    output logic [7:0] r_data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_M1  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta_q, rx_s_q;
    logic            ack_d_q;
    logic            irr_q, irr_d;
    logic [7:0]      r_data_q, r_data_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            ack_rise;
    logic            done_ok;
    logic            done_err;

    assign ack_rise = ack & ~ack_d_q;

    // Two-stage synchronizer for rx, preset to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic for the receive FSM, bit timer and shift register.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (timer_q == HALF_M1) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    // A line that is high again at mid-start was a glitch.
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == BIT_M1) begin
                    timer_d = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == BIT_M1) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        done_ok = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        done_err = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_BREAK: begin
                // Hold here while the line stays low so a break cannot
                // re-trigger a start.
                timer_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output/flag next values; a completing byte beats a coincident ack edge.
    always_comb begin
        irr_d       = irr_q;
        r_data_d    = r_data_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (done_ok) begin
            irr_d    = 1'b1;
            r_data_d = shift_q;
        end else if (ack_rise) begin
            irr_d = 1'b0;
        end else begin
            irr_d = irr_q;
        end
        if (done_err) begin
            frame_err_d = 1'b1;
        end else if (ack_rise) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
        // Overrun only when the pending byte is not being acknowledged now.
        if (done_ok && irr_q && !ack_rise) begin
            overrun_d = 1'b1;
        end else if (ack_rise) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            ack_d_q     <= 1'b0;
            irr_q       <= 1'b0;
            r_data_q    <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            ack_d_q     <= ack;
            irr_q       <= irr_d;
            r_data_q    <= r_data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign irr       = irr_q;
    assign r_data    = r_data_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_irq.md
# uart_rx_irq

Serial receive front end for the CPU's input channel. Deserialises 8N1 UART frames from the `rx` pin and presents each received byte on `r_data`, raising the `irr` interrupt request. `irr` stays asserted until the CPU acknowledges. The block sits directly upstream of the CPU's `irr`/`ack`/`r_data` inputs. The CPU samples `irr` and `r_data` only once every 4 cycles and holds `ack` high for a whole instruction window, so the handshake is edge-based on `ack`.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.

Ports:
- `clk`  input  1  clock; all state updates on its rising edge.
- `reset`  input  1  reset, synchronous, active-high.
- `rx`  input  1  asynchronous serial line; idles high.
- `ack`  input  1  CPU acknowledge, level. Only its rising edge is acted on.
- `irr`  output  1  interrupt request: a received byte is pending.
- `r_data`  output  8  last valid received byte.
- `frame_err`  output  1  sticky: a stop bit was sampled low.
- `overrun`  output  1  sticky: a byte completed while `irr` was already pending.

## Operation

- `rx` passes through a 2-FF synchronizer (`rx_s`) before any use.
- `ack_d` register; `ack_rise = ack & ~ack_d`.
- Bit timer: counter of width `$clog2(CLKS_PER_BIT)`, `HALF = CLKS_PER_BIT/2` (floor). Bit index is 3 bits. Data is shifted into an 8-bit shift register, LSB first.
- FSM states and transitions:
  - IDLE: when `rx_s == 0`, clear the timer and go to START.
  - START: after HALF cycles, sample `rx_s`. If 0, clear the timer and bit index and go to DATA. If 1, treat as a glitch and return to IDLE with no flags changed.
  - DATA: every CLKS_PER_BIT cycles, at the bit centre, shift in `rx_s`. After bit index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
    - If 1: load `r_data` from the shift register, set `irr`, and set `overrun` if `irr` was already 1 and not being cleared this cycle. Go to IDLE.
    - If 0: set `frame_err`, discard the byte (`r_data` and `irr` unchanged), and go to BREAK.
  - BREAK: wait until `rx_s == 1`, then go to IDLE. This prevents a held-low line from re-triggering.
- `ack_rise` clears `irr`, `frame_err` and `overrun`.
- Simultaneous byte-complete and `ack_rise`:
  - The completion wins: `irr` stays 1 and `r_data` takes the new byte.
  - `overrun` is not set.
  - `frame_err`/`overrun` are cleared by the ack except for a flag set by the same event.
- `ack` held high across multiple cycles clears only once. A byte completing while `ack` is still high stays pending.
- Reset returns the FSM to IDLE from any state. A partially received frame is dropped. The synchronizer is preset to 1 (idle).

## Timing

- Reset values: `irr = 0`, `r_data = 8'h00`, `frame_err = 0`, `overrun = 0`, FSM = IDLE, timer = 0, `ack_d = 0`, synchronizer FFs = 1.
- All outputs are registered; there is no combinational path from `rx` or `ack` to any output.
- Synchronizer latency is 2 cycles. A falling edge on the `rx` pin becomes visible in IDLE at cycle t+2, and START is entered at t+3.
- The start bit is checked HALF cycles after START entry. Data bit k is sampled (k+1)·CLKS_PER_BIT cycles after the start check; the stop bit is sampled at 9·CLKS_PER_BIT.
- `irr`, `r_data` and the flags update on the clock edge following the stop-bit sample.
- After a valid stop sample, the FSM is back in IDLE the next cycle. Back-to-back frames therefore need no extra idle time, beyond the stop bit, before the next start bit.
- `irr` falls on the cycle after the `ack` rising edge is registered, i.e. 1 cycle after `ack` goes high.

## Test plan

All scenarios use CLKS_PER_BIT = 16.
- Reset, then idle line for 100 cycles -> `irr = 0`, `r_data = 0x00`, both flags 0.
- Send frame 0xA5 (8N1) -> `irr` rises about 153 cycles after the start edge, `r_data = 0xA5`, `frame_err = 0`. Pulse `ack` for 4 cycles -> `irr = 0` one cycle after `ack` rises, and it does not re-clear.
- Send 0x3C then 0xC3 back-to-back without acking -> `r_data = 0xC3`, `irr = 1`, `overrun = 1`. Ack -> all three clear.
- Frame 0x55 with stop bit driven 0, line held low for 40 cycles, then high; then send 0x12 -> after the first frame `frame_err = 1`, `irr = 0`, `r_data` unchanged. After the second frame `r_data = 0x12`, `irr = 1`.
- 4-cycle low glitch on an idle line -> FSM returns to IDLE, no flag or output change. A following 0x7E frame is received correctly.
- `ack` rising edge coincident with completion of a second byte -> `irr` stays 1, `r_data` takes the new byte, `overrun = 0`. Assert `reset` mid-frame (during DATA) -> outputs go to reset values and the next full frame is received correctly.
